// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter (MMU, DBUS, IF) in front of a single memory port,
// with anti-starvation for instruction fetch and a watchdog on memory completion.
module mem_port_arbiter #(
   parameter int TIMEOUT    = 15,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        mmu_req_i,
   input  logic [31:0] mmu_addr_i,
   input  logic        dbus_req_i,
   input  logic [31:0] dbus_addr_i,
   input  logic        dbus_we_i,
   input  logic [3:0]  dbus_be_i,
   input  logic [31:0] dbus_wdata_i,
   output logic        if_ack_o,
   output logic        mmu_ack_o,
   output logic        dbus_ack_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        err_timeout_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {GNT_IF, GNT_MMU, GNT_DBUS} gnt_t;

   localparam int TW = (TIMEOUT    > 1) ? $clog2(TIMEOUT + 1)    : 1;
   localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_FULL = SW'(STARVE_MAX);

   state_t        state_q, state_d;
   gnt_t          gnt_q, gnt_sel;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic          we_q, err_q;
   logic [3:0]    be_q;
   logic [TW-1:0] tcnt_q;
   logic [SW-1:0] starve_q;
   logic          any_req, timed_out;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      gnt_sel   = GNT_IF;
      any_req   = if_req_i | mmu_req_i | dbus_req_i;
      timed_out = (state_q == ACCESS) && !mem_ack_i && (tcnt_q == TO_LAST);

      if (if_req_i && starve_q == STARVE_FULL) gnt_sel = GNT_IF;
      else if (mmu_req_i)                      gnt_sel = GNT_MMU;
      else if (dbus_req_i)                     gnt_sel = GNT_DBUS;

      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  if (mem_ack_i || timed_out) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_IF;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         tcnt_q   <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= timed_out;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  gnt_q  <= gnt_sel;
                  tcnt_q <= '0;
                  if (gnt_sel == GNT_DBUS) begin
                     addr_q  <= dbus_addr_i;
                     we_q    <= dbus_we_i;
                     be_q    <= dbus_be_i;
                     wdata_q <= dbus_wdata_i;
                  end else begin
                     addr_q  <= (gnt_sel == GNT_MMU) ? mmu_addr_i : if_addr_i;
                     we_q    <= 1'b0;
                     be_q    <= 4'hF;
                     wdata_q <= '0;
                  end
                  if (gnt_sel == GNT_IF)
                     starve_q <= '0;
                  else if (if_req_i && starve_q != STARVE_FULL)
                     starve_q <= starve_q + 1'b1;
               end
            end
            ACCESS: begin
               if (mem_ack_i)      rdata_q <= mem_rdata_i;
               else if (timed_out) rdata_q <= '0;
               else                tcnt_q  <= tcnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Memory-side fields are only driven while a transaction is in flight.
   assign mem_req_o     = (state_q == ACCESS);
   assign mem_addr_o    = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
   assign mem_we_o      = mem_req_o & we_q;
   assign mem_be_o      = mem_req_o ? be_q : '0;
   assign mem_wdata_o   = mem_req_o ? wdata_q : '0;

   assign if_ack_o      = (state_q == DONE) && (gnt_q == GNT_IF);
   assign mmu_ack_o     = (state_q == DONE) && (gnt_q == GNT_MMU);
   assign dbus_ack_o    = (state_q == DONE) && (gnt_q == GNT_DBUS);
   assign rdata_o       = (state_q == DONE) ? rdata_q : '0;
   assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: priority, writes,
// IF anti-starvation, timeout and asynchronous reset mid-access.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i, mmu_req_i, dbus_req_i, dbus_we_i, mem_ack_i;
   logic [31:0] if_addr_i, mmu_addr_i, dbus_addr_i, dbus_wdata_i, mem_rdata_i;
   logic [3:0]  dbus_be_i;
   logic        if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o, mem_we_o, err_timeout_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(15), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .mmu_req_i(mmu_req_i), .mmu_addr_i(mmu_addr_i),
      .dbus_req_i(dbus_req_i), .dbus_addr_i(dbus_addr_i),
      .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i), .dbus_wdata_i(dbus_wdata_i),
      .if_ack_o(if_ack_o), .mmu_ack_o(mmu_ack_o), .dbus_ack_o(dbus_ack_o),
      .rdata_o(rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .err_timeout_o(err_timeout_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if_req_i = 0; mmu_req_i = 0; dbus_req_i = 0; dbus_we_i = 0; mem_ack_i = 0;
      if_addr_i = '0; mmu_addr_i = '0; dbus_addr_i = '0; dbus_wdata_i = '0;
      dbus_be_i = '0; mem_rdata_i = '0;
      repeat (2) tick();
      checks++;
      if ({if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o, mem_we_o, err_timeout_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got acks/req/we/err=%b want 000000",
                  {if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o, mem_we_o, err_timeout_o});
      end
      checks++;
      if ({mem_addr_o, mem_wdata_o, rdata_o, mem_be_o} !== '0) begin
         errors++;
         $display("FAIL reset_data got addr=%h wdata=%h rdata=%h be=%h want all 0",
                  mem_addr_o, mem_wdata_o, rdata_o, mem_be_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_priority();
      logic [31:0] exp_addr [3];
      logic [31:0] rd       [3];
      logic [2:0]  exp_ack  [3];
      exp_addr = '{32'h0000_1004, 32'h0000_2000, 32'h0000_3000};
      rd       = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
      exp_ack  = '{3'b010, 3'b001, 3'b100};   // {if, mmu, dbus}
      mmu_req_i = 1; mmu_addr_i = 32'h0000_1006;
      dbus_req_i = 1; dbus_addr_i = 32'h0000_2001; dbus_we_i = 0; dbus_be_i = 4'hF;
      if_req_i = 1; if_addr_i = 32'h0000_3003;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr[k] || mem_we_o !== 1'b0 ||
             mem_be_o !== 4'hF) begin
            errors++;
            $display("FAIL prio_grant%0d got req=%b addr=%h we=%b be=%h want 1 %h 0 f",
                     k, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, exp_addr[k]);
         end
         checks++;
         if ({if_ack_o, mmu_ack_o, dbus_ack_o} !== 3'b000 || rdata_o !== '0) begin
            errors++;
            $display("FAIL prio_quiet%0d got acks=%b rdata=%h want 000 0",
                     k, {if_ack_o, mmu_ack_o, dbus_ack_o}, rdata_o);
         end
         mem_ack_i = 1; mem_rdata_i = rd[k];
         tick();
         mem_ack_i = 0; mem_rdata_i = '0;
         checks++;
         if ({if_ack_o, mmu_ack_o, dbus_ack_o} !== exp_ack[k] || rdata_o !== rd[k] ||
             mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_ack%0d got acks=%b rdata=%h req=%b want %b %h 0",
                     k, {if_ack_o, mmu_ack_o, dbus_ack_o}, rdata_o, mem_req_o, exp_ack[k], rd[k]);
         end
         case (k)
            0: mmu_req_i = 0;
            1: dbus_req_i = 0;
            default: if_req_i = 0;
         endcase
         tick();
         checks++;
         if ({if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o} !== 4'b0) begin
            errors++;
            $display("FAIL prio_idle%0d got acks/req=%b want 0000",
                     k, {if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o});
         end
      end
   endtask

   task automatic test_dbus_write();
      dbus_req_i = 1; dbus_addr_i = 32'h0000_0103; dbus_we_i = 1;
      dbus_be_i = 4'b0101; dbus_wdata_i = 32'hAABB_CCDD;
      tick();
      dbus_req_i = 0; dbus_we_i = 0; dbus_be_i = '0; dbus_wdata_i = '0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0100 || mem_we_o !== 1'b1 ||
             mem_be_o !== 4'b0101 || mem_wdata_o !== 32'hAABB_CCDD || dbus_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_fields%0d got req=%b addr=%h we=%b be=%b wdata=%h ack=%b want 1 00000100 1 0101 aabbccdd 0",
                     c, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, dbus_ack_o);
         end
         if (c < 2) tick();
      end
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0;
      checks++;
      if ({if_ack_o, mmu_ack_o, dbus_ack_o} !== 3'b001 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL wr_ack got acks=%b req=%b want 001 0", {if_ack_o, mmu_ack_o, dbus_ack_o}, mem_req_o);
      end
      tick();
      checks++;
      if (dbus_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL wr_pulse got ack=%b req=%b want 0 0", dbus_ack_o, mem_req_o);
      end
   endtask

   task automatic test_starve();
      logic [31:0] exp_addr;
      mmu_req_i = 1; mmu_addr_i = 32'h0000_5008;
      if_req_i = 1; if_addr_i = 32'h0000_600C;
      for (int k = 1; k <= 5; k++) begin
         exp_addr = (k == 5) ? 32'h0000_600C : 32'h0000_5008;
         tick();
         checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
            errors++;
            $display("FAIL starve_grant%0d got req=%b addr=%h want 1 %h", k, mem_req_o, mem_addr_o, exp_addr);
         end
         mem_ack_i = 1; mem_rdata_i = 32'h5000_0000 + k;
         tick();
         mem_ack_i = 0;
         checks++;
         if ({if_ack_o, mmu_ack_o} !== ((k == 5) ? 2'b10 : 2'b01) || rdata_o !== 32'h5000_0000 + k) begin
            errors++;
            $display("FAIL starve_ack%0d got if/mmu=%b rdata=%h want %b %h", k, {if_ack_o, mmu_ack_o},
                     rdata_o, (k == 5) ? 2'b10 : 2'b01, 32'h5000_0000 + k);
         end
         tick();
      end
      mmu_req_i = 0; if_req_i = 0; mem_rdata_i = '0;
      tick();
   endtask

   task automatic test_timeout();
      if_req_i = 1; if_addr_i = 32'h0000_0040;
      tick();
      if_req_i = 0;
      mem_rdata_i = 32'hDEAD_BEEF;
      repeat (14) tick();
      checks++;
      if (mem_req_o !== 1'b1 || if_ack_o !== 1'b0 || err_timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL to_wait got req=%b ack=%b err=%b want 1 0 0", mem_req_o, if_ack_o, err_timeout_o);
      end
      tick();
      checks++;
      if (if_ack_o !== 1'b1 || err_timeout_o !== 1'b1 || rdata_o !== '0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL to_done got ack=%b err=%b rdata=%h req=%b want 1 1 0 0",
                  if_ack_o, err_timeout_o, rdata_o, mem_req_o);
      end
      tick();
      mem_rdata_i = '0;
      checks++;
      if (if_ack_o !== 1'b0 || err_timeout_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL to_idle got ack=%b err=%b req=%b want 0 0 0", if_ack_o, err_timeout_o, mem_req_o);
      end
   endtask

   task automatic test_reset_mid_access();
      mmu_req_i = 1; mmu_addr_i = 32'h0000_3000;
      tick();
      mmu_req_i = 0;
      checks++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre got req=%b want 1", mem_req_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || mem_addr_o !== '0 || mem_be_o !== '0) begin
         errors++;
         $display("FAIL rst_async got req=%b addr=%h be=%h want 0 0 0", mem_req_o, mem_addr_o, mem_be_o);
      end
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0;
      tick();
      checks++;
      if ({if_ack_o, mmu_ack_o, dbus_ack_o, err_timeout_o} !== 4'b0) begin
         errors++;
         $display("FAIL rst_noack got acks/err=%b want 0000", {if_ack_o, mmu_ack_o, dbus_ack_o, err_timeout_o});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o} !== 4'b0) begin
         errors++;
         $display("FAIL rst_after got acks/req=%b want 0000", {if_ack_o, mmu_ack_o, dbus_ack_o, mem_req_o});
      end
      mmu_req_i = 1; mmu_addr_i = 32'h0000_2000;
      tick();
      mmu_req_i = 0;
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_2000 || mem_we_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_newreq got req=%b addr=%h we=%b want 1 00002000 0", mem_req_o, mem_addr_o, mem_we_o);
      end
      mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
      tick();
      mem_ack_i = 0; mem_rdata_i = '0;
      checks++;
      if ({if_ack_o, mmu_ack_o, dbus_ack_o} !== 3'b010 || rdata_o !== 32'h1234_5678) begin
         errors++;
         $display("FAIL rst_newack got acks=%b rdata=%h want 010 12345678", {if_ack_o, mmu_ack_o, dbus_ack_o}, rdata_o);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_dbus_write();
      test_starve();
      test_timeout();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning ACCESS cycles without mem_ack_i before forced completion.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive lost arbitrations before IF is force-granted.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req_i / if_addr_i  in  1 / 32  instruction fetch read request and byte address.
REQ-006 SHALL have port mmu_req_i / mmu_addr_i  in  1 / 32  page-walk read request and physical byte address.
REQ-007 SHALL have port dbus_req_i / dbus_addr_i  in  1 / 32  data bus request and byte address.
REQ-008 SHALL have port dbus_we_i / dbus_be_i / dbus_wdata_i  in  1 / 4 / 32  write enable, byte lanes, write data.
REQ-009 SHALL have port if_ack_o / mmu_ack_o / dbus_ack_o  out  1 each  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata_o  out  32  read data, shared, valid only while any ack_o is high.
REQ-011 SHALL have port mem_req_o / mem_addr_o / mem_we_o  out  1 / 32 / 1  shared memory port request, word address, write enable.
REQ-012 SHALL have port mem_be_o / mem_wdata_o  out  4 / 32  memory byte lanes and write data.
REQ-013 SHALL have port mem_ack_i / mem_rdata_i  in  1 / 32  memory completion and read data.
REQ-014 SHALL have port err_timeout_o  out  1  one-cycle pulse on forced completion.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-016 SHALL, in IDLE with any req_i high, grant by fixed priority MMU > DBUS > IF, latch grant id, addr, we, be, wdata, and go to ACCESS next cycle.
REQ-017 SHALL maintain a starve counter that increments when IF is pending in IDLE but not granted, clears when IF is granted, and saturates at STARVE_MAX.
REQ-018 SHALL grant IF over MMU and DBUS when the starve counter equals STARVE_MAX.
REQ-019 SHALL, in ACCESS, drive mem_req_o=1 with the latched fields held stable until completion.
REQ-020 SHALL drive mem_addr_o = latched addr with bits [1:0] forced to 0.
REQ-021 SHALL, for IF and MMU grants, drive mem_we_o=0 and mem_be_o=4'hF.
REQ-022 SHALL, for DBUS grants, drive mem_we_o and mem_be_o from the latched dbus fields.
REQ-023 SHALL, on mem_ack_i in ACCESS, capture mem_rdata_i into the rdata register and go to DONE.
REQ-024 SHALL count ACCESS cycles and, on reaching TIMEOUT without mem_ack_i, set rdata to 0, pulse err_timeout_o in the next cycle, and go to DONE.
REQ-025 SHALL, in DONE, pulse exactly the granted requester's ack_o for one cycle with rdata_o valid, ignore all req_i, and return to IDLE.
REQ-026 SHALL have best-case latency of request sampled in IDLE at cycle N, mem_req_o at N+1, ack_o at N+2 when mem_ack_i is seen at N+1.
REQ-027 SHALL, if the granted req_i drops mid-ACCESS, complete the transaction and still pulse ack_o.
REQ-028 SHALL drive mem_req_o=0 and all ack_o=0 in IDLE and DONE.
REQ-029 SHALL never have more than one ack_o high at a time.
REQ-030 SHALL drive rdata_o=0 whenever no ack_o is high.

Reset
REQ-031 SHALL, while rst_n=0, immediately force FSM=IDLE, starve counter=0, timeout counter=0, all ack_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_timeout_o=0.
REQ-032 SHALL, on reset asserted mid-ACCESS, abandon the transaction with no ack_o pulse, and restart arbitration from IDLE after reset release.

Verification
REQ-033 SHALL cover: all three req high, mem_ack_i 1 cycle after mem_req_o -> grant order MMU, DBUS, IF; each ack 2 cycles after its grant.
REQ-034 SHALL cover: DBUS write addr 0x103, be=4'b0101, wdata=0xAABBCCDD -> mem_addr_o=0x100, mem_we_o=1, mem_be_o=4'b0101, dbus_ack_o single pulse.
REQ-035 SHALL cover: IF held high with MMU continuously requesting -> IF granted on 5th arbitration (STARVE_MAX=4).
REQ-036 SHALL cover: mem_ack_i never asserted -> after 15 ACCESS cycles, err_timeout_o pulse, ack_o pulse, rdata_o=0, return to IDLE.
REQ-037 SHALL cover: rst_n low during ACCESS -> mem_req_o=0 without waiting for clk, no ack_o; after release, a new MMU read of 0x2000 completes normally.
